// File: rtl/dma_engine_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM encoding for the DMA engine.
// The interrupt feature is compiled in only when DMA_IRQ_EN is defined.
package dma_engine_pkg;

  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_regs.sv
// Config register file and slave decode: SRC/DST/LEN working registers, CTRL pulses, STATUS.
// CTRL.irq_en exists only when DMA_IRQ_EN is defined; otherwise it reads 0 and ignores writes.
module dma_regs
  import dma_engine_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_addr_i,
  input  logic              s_we_i,
  input  logic [DATA_W-1:0] s_wdata_i,
  output logic [DATA_W-1:0] s_rdata_o,
  input  logic              busy_i,
  input  logic              advance_i,
  input  logic              done_set_i,
  output logic [ADDR_W-1:0] src_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [DATA_W-1:0] len_o,
  output logic              start_o,
  output logic              abort_o,
  output logic              irq_en_o
);

  logic [2:0]        offs;
  logic [ADDR_W-1:0] wdata_addr;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [DATA_W-1:0] len_q;
  logic              done_q;
  logic              wr_src, wr_dst, wr_len, wr_ctrl, wr_status;
  logic              unused_addr;

  assign offs       = s_addr_i[4:2];
  assign unused_addr = ^s_addr_i;
  assign wdata_addr = ADDR_W'(s_wdata_i);

  assign wr_src    = s_we_i && (offs == REG_SRC);
  assign wr_dst    = s_we_i && (offs == REG_DST);
  assign wr_len    = s_we_i && (offs == REG_LEN);
  assign wr_ctrl   = s_we_i && (offs == REG_CTRL);
  assign wr_status = s_we_i && (offs == REG_STATUS);

  // start/abort are write strobes only; they are never stored
  assign start_o = wr_ctrl && s_wdata_i[CTRL_START];
  assign abort_o = wr_ctrl && s_wdata_i[CTRL_ABORT];

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (advance_i) begin
        src_q <= src_q + ADDR_W'(4);
        dst_q <= dst_q + ADDR_W'(4);
        len_q <= len_q - DATA_W'(1);
      end else if (!busy_i) begin
        if (wr_src) src_q <= wdata_addr & ~ADDR_W'(3);
        if (wr_dst) dst_q <= wdata_addr & ~ADDR_W'(3);
        if (wr_len) len_q <= s_wdata_i;
      end
      // entering DONE wins over a clearing write in the same cycle
      if (done_set_i)
        done_q <= 1'b1;
      else if (wr_status || abort_o || (start_o && !busy_i))
        done_q <= 1'b0;
    end
  end

`ifdef DMA_IRQ_EN
  logic irq_en_q;
  always_ff @(posedge clk) begin
    if (rst)          irq_en_q <= 1'b0;
    else if (wr_ctrl) irq_en_q <= s_wdata_i[CTRL_IRQ_EN];
  end
  assign irq_en_o = irq_en_q;
`else
  assign irq_en_o = 1'b0;
`endif

  always_comb begin
    s_rdata_o = '0;
    case (offs)
      REG_SRC:    s_rdata_o = DATA_W'(src_q);
      REG_DST:    s_rdata_o = DATA_W'(dst_q);
      REG_LEN:    s_rdata_o = len_q;
      REG_CTRL:   s_rdata_o[CTRL_IRQ_EN] = irq_en_o;
      REG_STATUS: begin
        s_rdata_o[STAT_BUSY] = busy_i;
        s_rdata_o[STAT_DONE] = done_q;
      end
      default:    s_rdata_o = '0;
    endcase
  end

  assign src_o = src_q;
  assign dst_o = dst_q;
  assign len_o = len_q;

endmodule

// File: rtl/dma_engine.sv
// Single-channel word-copy DMA: IDLE -> RD -> WR ... -> DONE, with registered master outputs.
// Define DMA_IRQ_EN to enable the one-cycle completion interrupt (irq_o is 0 otherwise).
module dma_engine
  import dma_engine_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_addr_i,
  input  logic              s_we_i,
  input  logic [DATA_W-1:0] s_wdata_i,
  output logic [DATA_W-1:0] s_rdata_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  input  logic [DATA_W-1:0] m_rdata_i,
  input  logic              m_grant_i,
  output logic              irq_o
);

  logic [ADDR_W-1:0] src, dst;
  logic [DATA_W-1:0] len;
  logic              start, abort, irq_en;
  logic              busy, len_zero, last_word, start_ok, advance, done_set;

  dma_state_e        state_q;
  logic              m_req_q, m_we_q, irq_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;

  assign busy      = (state_q == ST_RD) || (state_q == ST_WR);
  assign len_zero  = (len == '0);
  assign last_word = (len == DATA_W'(1));
  assign start_ok  = start && !busy && !abort;
  assign advance   = (state_q == ST_WR) && m_grant_i && !abort;
  assign done_set  = (start_ok && len_zero) || (advance && last_word);

  dma_regs #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .s_addr_i   (s_addr_i),
    .s_we_i     (s_we_i),
    .s_wdata_i  (s_wdata_i),
    .s_rdata_o  (s_rdata_o),
    .busy_i     (busy),
    .advance_i  (advance),
    .done_set_i (done_set),
    .src_o      (src),
    .dst_o      (dst),
    .len_o      (len),
    .start_o    (start),
    .abort_o    (abort),
    .irq_en_o   (irq_en)
  );

  // m_wdata_q doubles as the data buffer: it is loaded on the granted read
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q   <= ST_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        ST_RD: begin
          if (m_grant_i) begin
            state_q   <= ST_WR;
            m_we_q    <= 1'b1;
            m_addr_q  <= dst;
            m_wdata_q <= m_rdata_i;
          end
        end
        ST_WR: begin
          if (m_grant_i) begin
            m_we_q    <= 1'b0;
            m_wdata_q <= '0;
            if (last_word) begin
              state_q  <= ST_DONE;
              m_req_q  <= 1'b0;
              m_addr_q <= '0;
              irq_q    <= irq_en;
            end else begin
              state_q  <= ST_RD;
              m_addr_q <= src + ADDR_W'(4);
            end
          end
        end
        default: begin
          if (start_ok && len_zero) begin
            state_q <= ST_DONE;
            irq_q   <= irq_en;
          end else if (start_ok) begin
            state_q  <= ST_RD;
            m_req_q  <= 1'b1;
            m_addr_q <= src;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign m_req_o   = m_req_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: register vector table plus hand-written transfer sequences.
`timescale 1ns/1ps
module tb_dma_engine;
  import dma_engine_pkg::*;

`ifdef DMA_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif
  localparam logic [31:0] PAT = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_addr_i, s_wdata_i, s_rdata_o;
  logic        s_we_i;
  logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic        m_req_o, m_we_o, m_grant_i, irq_o;

  dma_engine #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_addr_i  (s_addr_i),
    .s_we_i    (s_we_i),
    .s_wdata_i (s_wdata_i),
    .s_rdata_o (s_rdata_o),
    .m_addr_o  (m_addr_o),
    .m_wdata_o (m_wdata_o),
    .m_req_o   (m_req_o),
    .m_we_o    (m_we_o),
    .m_rdata_i (m_rdata_i),
    .m_grant_i (m_grant_i),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  // Memory model: every source word reads as its address XOR PAT
  assign m_rdata_i = m_addr_o ^ PAT;

  int          tests = 0;
  int          fails = 0;
  int          irq_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] wmem [logic [31:0]];
  logic [31:0] rd_log [$];

  always @(posedge clk) begin
    if (!rst && m_req_o && m_grant_i) begin
      if (m_we_o) wmem[m_addr_o] = m_wdata_o;
      else        rd_log.push_back(m_addr_o);
    end
  end

  always @(negedge clk) begin
    if (irq_o)   irq_cnt++;
    if (m_req_o) req_cnt++;
  end

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("[TB] %-20s = 0x%08h ok", name, act);
    end
  endtask

  function automatic logic [31:0] ra(input logic [2:0] off);
    return {27'd0, off, 2'b00};
  endfunction

  function automatic logic [31:0] wm(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    @(negedge clk);
    s_addr_i = ra(off); s_wdata_i = d; s_we_i = 1'b1;
    @(negedge clk);
    s_we_i = 1'b0; #1;
  endtask

  task automatic chk_reg(input string name, input logic [2:0] off, input logic [31:0] exp);
    s_addr_i = ra(off); #1;
    check(name, s_rdata_o, exp);
  endtask

  // Writes CTRL, then counts cycles after the write edge until STATUS.done
  task automatic run_xfer(input logic [31:0] ctrl, input int limit, output int cyc);
    @(negedge clk);
    s_addr_i = ra(REG_CTRL); s_wdata_i = ctrl; s_we_i = 1'b1;
    @(negedge clk);
    s_we_i = 1'b0; s_addr_i = ra(REG_STATUS); #1;
    cyc = 1;
    while (s_rdata_o[STAT_DONE] !== 1'b1 && cyc < limit) begin
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before 400us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc, irq0, req0;
    logic        ok;
    logic [31:0] d;

    rst = 1'b1; s_addr_i = '0; s_we_i = 1'b0; s_wdata_i = '0; m_grant_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_req", 32'(m_req_o), 32'd0);
    check("rst_m_addr", m_addr_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    rst = 1'b0;

    // Register access table: optional write, then read back the same offset
    vecs[0] = '{1'b0, REG_SRC,    32'h0,      32'h0};
    vecs[1] = '{1'b0, REG_STATUS, 32'h0,      32'h0};
    vecs[2] = '{1'b1, REG_SRC,    32'h1003,   32'h1000};
    vecs[3] = '{1'b1, REG_DST,    32'h2006,   32'h2004};
    vecs[4] = '{1'b1, REG_LEN,    32'h5,      32'h5};
    vecs[5] = '{1'b1, REG_CTRL,   32'h2,      IRQ_BUILD ? 32'h2 : 32'h0};
    vecs[6] = '{1'b1, 3'd5,       32'hFFFF,   32'h0};
    vecs[7] = '{1'b1, 3'd7,       32'h1234,   32'h0};
    vecs[8] = '{1'b1, REG_STATUS, 32'h3,      32'h0};
    vecs[9] = '{1'b1, REG_CTRL,   32'h0,      32'h0};
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) wr(vecs[i].off, vecs[i].wdata);
      chk_reg($sformatf("vec%0d_off%0d", i, vecs[i].off), vecs[i].off, vecs[i].exp);
    end

    // Three-word copy with constant grant
    wr(REG_SRC, 32'h100); wr(REG_DST, 32'h200); wr(REG_LEN, 32'd3);
    wmem.delete(); rd_log.delete(); m_grant_i = 1'b1; irq0 = irq_cnt;
    run_xfer(32'h3, 40, cyc);
    check("a_done_cycle", 32'(cyc), 32'd7);
    check("a_status", s_rdata_o, 32'h2);
    check("a_reads", 32'(rd_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("a_word%0d", i), wm(32'h200 + 32'(4 * i)), (32'h100 + 32'(4 * i)) ^ PAT);
    repeat (2) @(negedge clk);
    #1;
    check("a_irq_pulses", 32'(irq_cnt - irq0), 32'(IRQ_BUILD));
    chk_reg("a_len_end", REG_LEN, 32'd0);
    chk_reg("a_src_end", REG_SRC, 32'h10C);

    // Zero-length start: straight to DONE, no bus activity
    wr(REG_LEN, 32'd0); wr(REG_STATUS, 32'd0);
    chk_reg("b_done_cleared", REG_STATUS, 32'd0);
    req0 = req_cnt; irq0 = irq_cnt;
    run_xfer(32'h3, 10, cyc);
    check("b_done_cycle", 32'(cyc), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check("b_no_req", 32'(req_cnt - req0), 32'd0);
    check("b_irq_pulses", 32'(irq_cnt - irq0), 32'(IRQ_BUILD));

    // Grant withheld 5 cycles in RD and then in WR
    wr(REG_SRC, 32'h300); wr(REG_DST, 32'h400); wr(REG_LEN, 32'd2);
    wmem.delete(); rd_log.delete(); m_grant_i = 1'b0;
    @(negedge clk);
    s_addr_i = ra(REG_CTRL); s_wdata_i = 32'h1; s_we_i = 1'b1;
    @(negedge clk);
    s_we_i = 1'b0; #1;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!(m_req_o === 1'b1 && m_we_o === 1'b0 && m_addr_o === 32'h300)) ok = 1'b0;
      @(negedge clk); #1;
    end
    check("c_rd_hold", 32'(ok), 32'd1);
    m_grant_i = 1'b1;
    @(negedge clk);
    m_grant_i = 1'b0; #1;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_addr_i = ra(REG_LEN); #1;
      if (!(m_req_o === 1'b1 && m_we_o === 1'b1 && m_addr_o === 32'h400 &&
            m_wdata_o === (32'h300 ^ PAT) && s_rdata_o === 32'd2)) ok = 1'b0;
      @(negedge clk); #1;
    end
    check("c_wr_hold", 32'(ok), 32'd1);
    m_grant_i = 1'b1;
    @(negedge clk); #1;
    chk_reg("c_len_after_wr", REG_LEN, 32'd1);
    check("c_next_rd_addr", m_addr_o, 32'h304);
    s_addr_i = ra(REG_STATUS); #1;
    cyc = 0;
    while (s_rdata_o[STAT_DONE] !== 1'b1 && cyc < 10) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("c_word0", wm(32'h400), 32'h300 ^ PAT);
    check("c_word1", wm(32'h404), 32'h304 ^ PAT);

    // Source address wraps past the top of the address space
    wr(REG_SRC, 32'hFFFF_FFFC); wr(REG_DST, 32'h500); wr(REG_LEN, 32'd2);
    wmem.delete(); rd_log.delete(); m_grant_i = 1'b1;
    run_xfer(32'h1, 20, cyc);
    check("d_done_cycle", 32'(cyc), 32'd5);
    check("d_rd1_addr", (rd_log.size() >= 2) ? rd_log[1] : 32'hxxxx_xxxx, 32'h0);
    check("d_word1", wm(32'h504), PAT);
    chk_reg("d_src_end", REG_SRC, 32'h4);

    // Abort during WR of word 2 of 4; SRC/DST writes while busy are dropped
    wr(REG_SRC, 32'h600); wr(REG_DST, 32'h700); wr(REG_LEN, 32'd4);
    wmem.delete(); rd_log.delete(); m_grant_i = 1'b1; irq0 = irq_cnt;
    @(negedge clk);
    s_addr_i = ra(REG_CTRL); s_wdata_i = 32'h1; s_we_i = 1'b1;
    @(negedge clk);
    s_addr_i = ra(REG_SRC); s_wdata_i = 32'hABC0;
    @(negedge clk);
    s_addr_i = ra(REG_DST); s_wdata_i = 32'hDEF0;
    @(negedge clk);
    s_we_i = 1'b0;
    @(negedge clk); #1;
    check("e_in_wr2", {m_we_o, m_addr_o[30:0]}, {1'b1, 31'h704});
    m_grant_i = 1'b0;
    s_addr_i = ra(REG_CTRL); s_wdata_i = 32'h4; s_we_i = 1'b1;
    @(negedge clk);
    s_we_i = 1'b0; #1;
    check("e_req_off", 32'(m_req_o), 32'd0);
    chk_reg("e_status", REG_STATUS, 32'd0);
    chk_reg("e_len", REG_LEN, 32'd3);
    chk_reg("e_src", REG_SRC, 32'h604);
    chk_reg("e_dst", REG_DST, 32'h704);
    check("e_word0", wm(32'h700), 32'h600 ^ PAT);
    check("e_no_word1", 32'(wmem.exists(32'h704)), 32'd0);
    wr(REG_CTRL, 32'h5);
    chk_reg("e_abort_beats_start", REG_STATUS, 32'd0);
    check("e_irq_none", 32'(irq_cnt - irq0), 32'd0);

    // Reset in the middle of RD, with grant asserted in the same cycle
    wr(REG_SRC, 32'h800); wr(REG_DST, 32'h900); wr(REG_LEN, 32'd2);
    wmem.delete(); m_grant_i = 1'b0;
    @(negedge clk);
    s_addr_i = ra(REG_CTRL); s_wdata_i = 32'h3; s_we_i = 1'b1;
    @(negedge clk);
    s_we_i = 1'b0; #1;
    check("f_in_rd", {m_req_o, m_addr_o[30:0]}, {1'b1, 31'h800});
    rst = 1'b1; m_grant_i = 1'b1;
    @(negedge clk); #1;
    check("f_req", 32'(m_req_o), 32'd0);
    check("f_addr", m_addr_o, 32'd0);
    check("f_wdata_we", {m_we_o, m_wdata_o[30:0]}, 32'd0);
    chk_reg("f_src", REG_SRC, 32'd0);
    chk_reg("f_dst", REG_DST, 32'd0);
    chk_reg("f_len", REG_LEN, 32'd0);
    chk_reg("f_ctrl", REG_CTRL, 32'd0);
    chk_reg("f_status", REG_STATUS, 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("f_post_req", 32'(m_req_o), 32'd0);
    check("f_no_write", 32'(wmem.exists(32'h900)), 32'd0);

    check("irq_total", 32'(irq_cnt), IRQ_BUILD ? 32'd2 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
